// File: rtl/nand_chain_pkg.sv
// rtl/nand_chain_pkg.sv - shared types, constants and golden function for the NAND chain checker
package nand_chain_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int         NUM_VECTORS = 16;
    localparam logic [3:0] LAST_VEC    = 4'(NUM_VECTORS - 1);

    // Expected taps {e,f,g} for vec = {d,c,b,a}.
    function automatic logic [2:0] nand_chain_expect(input logic [3:0] vec);
        logic e;
        logic f;
        logic g;
        e = ~(vec[0] & vec[1]);
        f = ~(vec[2] & e);
        g = ~(vec[3] & f);
        return {e, f, g};
    endfunction

endpackage

// File: rtl/nand_chain_model.sv
// rtl/nand_chain_model.sv - combinational golden model of the cascaded NAND chain
// Ports: a,b,c,d in; e=~(a&b), f=~(c&e), g=~(d&f) out.
module nand_chain_model
    import nand_chain_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic e,
    output logic f,
    output logic g
);

    assign {e, f, g} = nand_chain_expect({d, c, b, a});

endmodule

// File: rtl/nand_chain_exhaustive_checker.sv
// rtl/nand_chain_exhaustive_checker.sv - sweeps all 16 chain inputs and checks taps e,f,g
// Ports: clk, rst (sync, active-high), start pulse; a..d stimulus out; dut_e/f/g taps in;
// busy, done, pass, err_count (saturating), fail_vec/fail_obs (first failure) out.
module nand_chain_exhaustive_checker
    import nand_chain_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    input  logic             dut_e,
    input  logic             dut_f,
    input  logic             dut_g,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec,
    output logic [2:0]       fail_obs
);

    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};
    localparam logic [3:0]       SETTLE_END = 4'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_n;
    logic [3:0]       vec;
    logic [3:0]       vec_n;
    logic [3:0]       cnt;
    logic [3:0]       cnt_n;
    logic [ERR_W-1:0] err_n;
    logic [3:0]       fail_vec_n;
    logic [2:0]       fail_obs_n;
    logic             first_seen;
    logic             first_seen_n;
    logic             exp_e;
    logic             exp_f;
    logic             exp_g;
    logic             mismatch;

    // Expected taps come from the internal vector, not from the driven pins,
    // so a stuck upstream tap cannot mask a downstream check.
    nand_chain_model u_model (
        .a (vec[0]),
        .b (vec[1]),
        .c (vec[2]),
        .d (vec[3]),
        .e (exp_e),
        .f (exp_f),
        .g (exp_g)
    );

    assign mismatch = ({dut_e, dut_f, dut_g} != {exp_e, exp_f, exp_g});

    always_comb begin
        state_n      = state;
        vec_n        = vec;
        cnt_n        = cnt;
        err_n        = err_count;
        fail_vec_n   = fail_vec;
        fail_obs_n   = fail_obs;
        first_seen_n = first_seen;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n      = DRIVE;
                    vec_n        = 4'd0;
                    cnt_n        = 4'd0;
                    err_n        = '0;
                    fail_vec_n   = 4'd0;
                    fail_obs_n   = 3'd0;
                    first_seen_n = 1'b0;
                end
            end
            DRIVE: begin
                cnt_n = cnt + 4'd1;
                if (cnt == SETTLE_END) begin
                    state_n = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (err_count != ERR_MAX) begin
                        err_n = err_count + ERR_W'(1);
                    end
                    if (!first_seen) begin
                        first_seen_n = 1'b1;
                        fail_vec_n   = vec;
                        fail_obs_n   = {dut_e, dut_f, dut_g};
                    end
                end
                if (vec == LAST_VEC) begin
                    state_n = DONE;
                end else begin
                    vec_n   = vec + 4'd1;
                    cnt_n   = 4'd0;
                    state_n = DRIVE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Status outputs are registered from next-state values so they line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= 4'd0;
            cnt        <= 4'd0;
            first_seen <= 1'b0;
            err_count  <= '0;
            fail_vec   <= 4'd0;
            fail_obs   <= 3'd0;
            {d, c, b, a} <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            state      <= state_n;
            vec        <= vec_n;
            cnt        <= cnt_n;
            first_seen <= first_seen_n;
            err_count  <= err_n;
            fail_vec   <= fail_vec_n;
            fail_obs   <= fail_obs_n;
            {d, c, b, a} <= vec_n;
            busy       <= (state_n == DRIVE) || (state_n == SAMPLE);
            done       <= (state_n == DONE);
            pass       <= (state_n == DONE) && (err_n == '0);
        end
    end

endmodule
